// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, write-allocate cache controller in front of a 1-cycle word RAM.
// Optional hit/miss statistics counters are enabled with `define CACHE_STATS_EN.
module dm_cache_ctrl #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int INDEX_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_wdata,
    input  logic                  cpu_flush,
    output logic                  cpu_ready,
    output logic                  cpu_resp_valid,
    output logic [WIDTH-1:0]      cpu_rdata,
    output logic                  cpu_hit,
    output logic [WIDTH-1:0]      mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [WIDTH-1:0]      mem_data_out,
    input  logic                  mem_valid_out
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]           hit_count,
    output logic [15:0]           miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS;

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [WIDTH-1:0]      r_data [LINES];
    logic [ADDR_WIDTH-1:0] r_miss_addr;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_BITS-1:0] w_miss_idx;
    logic [TAG_W-1:0]      w_miss_tag;
    logic                  w_hit;
    logic                  w_accept;

    logic                  w_line_we;
    logic [INDEX_BITS-1:0] w_line_idx;
    logic [TAG_W-1:0]      w_line_tag;
    logic [WIDTH-1:0]      w_line_data;

    assign w_idx      = cpu_addr[INDEX_BITS-1:0];
    assign w_tag      = cpu_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign w_miss_idx = r_miss_addr[INDEX_BITS-1:0];
    assign w_miss_tag = r_miss_addr[ADDR_WIDTH-1:INDEX_BITS];
    assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign cpu_ready  = (r_state == IDLE);
    assign w_accept   = cpu_ready && !cpu_flush && cpu_req;

    // Tag/data arrays are written by either a CPU write or a refill; validity is tracked separately.
    always_comb begin
        w_line_we   = 1'b0;
        w_line_idx  = w_idx;
        w_line_tag  = w_tag;
        w_line_data = cpu_wdata;
        if (r_state == IDLE) begin
            w_line_we = w_accept && cpu_we;
        end else if (mem_valid_out) begin
            w_line_we   = 1'b1;
            w_line_idx  = w_miss_idx;
            w_line_tag  = w_miss_tag;
            w_line_data = mem_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (w_line_we) begin
            r_tag[w_line_idx]  <= w_line_tag;
            r_data[w_line_idx] <= w_line_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_valid          <= '0;
            r_miss_addr      <= '0;
            cpu_resp_valid   <= 1'b0;
            cpu_rdata        <= '0;
            cpu_hit          <= 1'b0;
            mem_data_in      <= '0;
            mem_addr         <= '0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
        end else begin
            cpu_resp_valid   <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cpu_flush) begin
                        r_valid <= '0;
                    end else if (cpu_req) begin
                        if (cpu_we) begin
                            r_valid[w_idx]   <= 1'b1;
                            mem_write_enable <= 1'b1;
                            mem_addr         <= cpu_addr;
                            mem_data_in      <= cpu_wdata;
                            cpu_resp_valid   <= 1'b1;
                            cpu_hit          <= w_hit;
                        end else if (w_hit) begin
                            cpu_resp_valid <= 1'b1;
                            cpu_hit        <= 1'b1;
                            cpu_rdata      <= r_data[w_idx];
                        end else begin
                            mem_read_enable <= 1'b1;
                            mem_addr        <= cpu_addr;
                            r_miss_addr     <= cpu_addr;
                            r_state         <= WAIT_MEM;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (mem_valid_out) begin
                        r_valid[w_miss_idx] <= 1'b1;
                        cpu_resp_valid      <= 1'b1;
                        cpu_hit             <= 1'b0;
                        cpu_rdata           <= mem_data_out;
                        r_state             <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic w_cnt_hit;
    logic w_cnt_miss;

    // Count in the same cycle the response pulse is being generated.
    always_comb begin
        w_cnt_hit  = 1'b0;
        w_cnt_miss = 1'b0;
        if (r_state == IDLE) begin
            if (w_accept && (cpu_we || w_hit)) begin
                w_cnt_hit  = w_hit;
                w_cnt_miss = !w_hit;
            end
        end else if (mem_valid_out) begin
            w_cnt_miss = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (cpu_ready && cpu_flush)) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_cnt_hit && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if (w_cnt_miss && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: bench-side 1-cycle RAM plus an address-level cache/memory model.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;

    localparam int W     = 32;
    localparam int AW    = 4;
    localparam int IB    = 2;
    localparam int LINES = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_flush;
    logic [AW-1:0] cpu_addr;
    logic [W-1:0]  cpu_wdata;
    logic          cpu_ready, cpu_resp_valid, cpu_hit;
    logic [W-1:0]  cpu_rdata;
    logic [W-1:0]  mem_data_in;
    logic [AW-1:0] mem_addr;
    logic          mem_write_enable, mem_read_enable;
    logic [W-1:0]  mem_data_out = '0;
    logic          mem_valid_out = 1'b0;
`ifdef CACHE_STATS_EN
    logic [15:0]   hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    dm_cache_ctrl #(.WIDTH(W), .ADDR_WIDTH(AW), .INDEX_BITS(IB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush), .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_data_in(mem_data_in), .mem_addr(mem_addr),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // Backing RAM with one-cycle read latency; deliberately not reset.
    logic [W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_addr] <= mem_data_in;
        mem_valid_out <= mem_read_enable;
        if (mem_read_enable) mem_data_out <= ram[mem_addr];
    end

    // Reference model: what memory should hold, and which full address each line currently caches.
    logic [W-1:0]  gold [DEPTH];
    bit            m_valid [LINES];
    logic [AW-1:0] m_addr  [LINES];

    int n_cmp = 0;
    int n_bad = 0;

    // Observations collected by do_op
    int           o_valid, o_hit, o_lat, o_re, o_we, o_both;
    logic [W-1:0] o_rdata, o_we_data;
    logic [AW-1:0] o_re_addr, o_we_addr;

    function automatic bit model_hit(input logic [AW-1:0] a);
        return m_valid[a % LINES] && (m_addr[a % LINES] == a);
    endfunction

    function automatic void model_apply(input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
        if (we) gold[a] = d;
        m_valid[a % LINES] = 1'b1;
        m_addr[a % LINES]  = a;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic do_op(input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
        int n;
        o_valid = 0; o_hit = 0; o_lat = 0; o_re = 0; o_we = 0; o_both = 0;
        o_rdata = '0; o_we_data = '0; o_re_addr = '0; o_we_addr = '0;
        n = 0;
        while (!cpu_ready && n < 20) begin @(posedge clk); #1; n++; end
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        n = 1;
        while (1) begin
            if (mem_read_enable) begin o_re++; o_re_addr = mem_addr; end
            if (mem_write_enable) begin o_we++; o_we_addr = mem_addr; o_we_data = mem_data_in; end
            if (mem_read_enable && mem_write_enable) o_both = 1;
            if (cpu_resp_valid) begin
                o_valid = 1; o_hit = int'(cpu_hit); o_rdata = cpu_rdata; o_lat = n;
                break;
            end
            if (n >= 20) break;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_flush(input bit with_req);
        cpu_flush = 1'b1; cpu_req = with_req; cpu_we = 1'b0; cpu_addr = 4'h2;
        @(posedge clk); #1;
        cpu_flush = 1'b0; cpu_req = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (cpu_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", cpu_ready); end
        n_cmp++; if (cpu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp: got %b expected 0", cpu_resp_valid); end
        n_cmp++; if (cpu_rdata !== '0 || cpu_hit !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_out: got rdata %h hit %b expected 0/0", cpu_rdata, cpu_hit); end
        n_cmp++; if (mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got re %b we %b expected 0/0", mem_read_enable, mem_write_enable); end
        n_cmp++; if (mem_addr !== '0 || mem_data_in !== '0) begin n_bad++; $display("FAIL rst_mem_bus: got addr %h data %h expected 0/0", mem_addr, mem_data_in); end
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_first_miss();
        do_op(1'b0, 4'h5, '0);
        n_cmp++; if (o_re !== 1 || o_re_addr !== 4'h5) begin n_bad++; $display("FAIL miss_rdreq: got %0d pulses addr %h expected 1 at 5", o_re, o_re_addr); end
        n_cmp++; if (o_lat !== 3) begin n_bad++; $display("FAIL miss_latency: got %0d expected 3", o_lat); end
        n_cmp++; if (o_hit !== 0 || o_rdata !== gold[5]) begin n_bad++; $display("FAIL miss_resp: got hit %0d data %h expected 0 %h", o_hit, o_rdata, gold[5]); end
        model_apply(1'b0, 4'h5, '0);
    endtask

    task automatic test_write_then_read();
        do_op(1'b1, 4'h5, 32'hDEADBEEF);
        n_cmp++; if (o_we !== 1 || o_we_addr !== 4'h5 || o_we_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_mem: got %0d pulses addr %h data %h expected 1 5 deadbeef", o_we, o_we_addr, o_we_data); end
        n_cmp++; if (o_valid !== 1 || o_lat !== 1 || o_hit !== 1) begin n_bad++; $display("FAIL wr_ack: got valid %0d lat %0d hit %0d expected 1 1 1", o_valid, o_lat, o_hit); end
        model_apply(1'b1, 4'h5, 32'hDEADBEEF);
        do_op(1'b0, 4'h5, '0);
        n_cmp++; if (o_hit !== 1 || o_lat !== 1 || o_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_after_wr: got hit %0d lat %0d data %h expected 1 1 deadbeef", o_hit, o_lat, o_rdata); end
        n_cmp++; if (o_re !== 0) begin n_bad++; $display("FAIL rd_hit_no_mem: got %0d read pulses expected 0", o_re); end
    endtask

    task automatic test_conflict();
        do_op(1'b1, 4'h1, 32'h11); model_apply(1'b1, 4'h1, 32'h11);
        do_op(1'b1, 4'h9, 32'h22); model_apply(1'b1, 4'h9, 32'h22);
        do_op(1'b0, 4'h1, '0);
        n_cmp++; if (o_hit !== 0 || o_re !== 1 || o_rdata !== 32'h11) begin n_bad++; $display("FAIL conflict_rd1: got hit %0d re %0d data %h expected 0 1 11", o_hit, o_re, o_rdata); end
        model_apply(1'b0, 4'h1, '0);
        do_op(1'b0, 4'h9, '0);
        n_cmp++; if (o_hit !== 0 || o_re !== 1 || o_rdata !== 32'h22) begin n_bad++; $display("FAIL conflict_rd9: got hit %0d re %0d data %h expected 0 1 22", o_hit, o_re, o_rdata); end
        model_apply(1'b0, 4'h9, '0);
    endtask

    task automatic test_flush();
        for (int a = 0; a < 4; a++) begin
            do_op(1'b0, AW'(a), '0);
            model_apply(1'b0, AW'(a), '0);
        end
        do_flush(1'b1);
        n_cmp++; if (cpu_resp_valid !== 1'b0 || mem_read_enable !== 1'b0 || cpu_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ignores_req: got resp %b re %b ready %b expected 0 0 1", cpu_resp_valid, mem_read_enable, cpu_ready); end
        do_op(1'b0, 4'h2, '0);
        n_cmp++; if (o_hit !== 0 || o_re !== 1 || o_lat !== 3) begin n_bad++; $display("FAIL flush_then_miss: got hit %0d re %0d lat %0d expected 0 1 3", o_hit, o_re, o_lat); end
        model_apply(1'b0, 4'h2, '0);
    endtask

    task automatic test_reset_mid_miss();
        do_flush(1'b0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h7;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        n_cmp++; if (mem_read_enable !== 1'b1 || cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_wait: got re %b ready %b expected 1 0", mem_read_enable, cpu_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        n_cmp++; if (cpu_resp_valid !== 1'b0 || cpu_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle: got resp %b ready %b expected 0 1", cpu_resp_valid, cpu_ready); end
        @(posedge clk); #1;
        n_cmp++; if (cpu_resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_late_resp: got %b expected 0", cpu_resp_valid); end
        do_op(1'b0, 4'h7, '0);
        n_cmp++; if (o_hit !== 0 || o_re !== 1 || o_rdata !== gold[7]) begin n_bad++; $display("FAIL rstmid_rdmiss: got hit %0d re %0d data %h expected 0 1 %h", o_hit, o_re, o_rdata, gold[7]); end
        model_apply(1'b0, 4'h7, '0);
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a;
        for (int i = 0; i < 4; i++) begin
            a = AW'(i + 4);
            do_op(1'b1, a, $urandom);
            model_apply(1'b1, a, o_we_data);
        end
        for (int i = 0; i < 10; i++) begin
            a = AW'($urandom_range(4, 7));
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
            @(posedge clk); #1;
            n_cmp++;
            if (cpu_resp_valid !== 1'b1 || cpu_hit !== 1'b1 || cpu_rdata !== gold[a] || mem_read_enable !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_hit: addr %h got valid %b hit %b data %h re %b expected 1 1 %h 0", a, cpu_resp_valid, cpu_hit, cpu_rdata, mem_read_enable, gold[a]);
            end
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit            we, exp_hit;
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                do_flush(1'($urandom));
                n_cmp++; if (cpu_resp_valid !== 1'b0 || mem_read_enable !== 1'b0 || mem_write_enable !== 1'b0) begin n_bad++; $display("FAIL rnd_flush: got resp %b re %b we %b expected 0 0 0", cpu_resp_valid, mem_read_enable, mem_write_enable); end
                continue;
            end
            we = 1'($urandom); a = AW'($urandom_range(0, 15)); d = $urandom;
            exp_hit = model_hit(a);
            do_op(we, a, d);
            n_cmp++; if (o_valid !== 1 || o_hit !== int'(exp_hit)) begin n_bad++; $display("FAIL rnd_hit: op %0d we %0d addr %h got valid %0d hit %0d expected 1 %0d", i, we, a, o_valid, o_hit, exp_hit); end
            n_cmp++; if (o_lat !== ((we || exp_hit) ? 1 : 3)) begin n_bad++; $display("FAIL rnd_lat: op %0d got %0d expected %0d", i, o_lat, (we || exp_hit) ? 1 : 3); end
            n_cmp++; if (o_both !== 0 || o_re !== ((!we && !exp_hit) ? 1 : 0) || o_we !== (we ? 1 : 0)) begin n_bad++; $display("FAIL rnd_mem_pulses: op %0d got re %0d we %0d both %0d", i, o_re, o_we, o_both); end
            if (we) begin
                n_cmp++; if (o_we_addr !== a || o_we_data !== d) begin n_bad++; $display("FAIL rnd_wr_bus: op %0d got %h/%h expected %h/%h", i, o_we_addr, o_we_data, a, d); end
            end else begin
                n_cmp++; if (o_rdata !== gold[a]) begin n_bad++; $display("FAIL rnd_rdata: op %0d addr %h got %h expected %h", i, a, o_rdata, gold[a]); end
                if (!exp_hit) begin
                    n_cmp++; if (o_re_addr !== a) begin n_bad++; $display("FAIL rnd_rd_addr: op %0d got %h expected %h", i, o_re_addr, a); end
                end
            end
            model_apply(we, a, d);
        end
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        do_flush(1'b0);
        n_cmp++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_bad++; $display("FAIL stats_clear0: got %0d/%0d expected 0/0", hit_count, miss_count); end
        do_op(1'b0, 4'h8, '0); model_apply(1'b0, 4'h8, '0);
        do_op(1'b0, 4'h9, '0); model_apply(1'b0, 4'h9, '0);
        do_op(1'b0, 4'h8, '0);
        do_op(1'b0, 4'h9, '0);
        do_op(1'b1, 4'h8, 32'h5A5A); model_apply(1'b1, 4'h8, 32'h5A5A);
        @(posedge clk); #1;
        n_cmp++; if (hit_count !== 16'd3 || miss_count !== 16'd2) begin n_bad++; $display("FAIL stats_count: got hit %0d miss %0d expected 3 2", hit_count, miss_count); end
        do_flush(1'b0);
        n_cmp++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin n_bad++; $display("FAIL stats_flush: got %0d/%0d expected 0/0", hit_count, miss_count); end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = '0;
            gold[i] = '0;
        end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_flush = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        reset = 1'b1;
        test_reset();
        test_first_miss();
        test_write_then_read();
        test_conflict();
        test_flush();
        test_reset_mid_miss();
        test_back_to_back();
        test_random();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
